// File: rtl/mdio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdio_pkg : shared MDIO frame constants, FSM state encoding, opcode |
// | helpers.                                         Revision: 1.0     |
// +--------------------------------------------------------------------+
package mdio_pkg;

    typedef enum logic [2:0] {
        STATE_IDLE = 3'd0,
        STATE_PRE  = 3'd1,
        STATE_HDR  = 3'd2,
        STATE_TA   = 3'd3,
        STATE_DATA = 3'd4,
        STATE_DONE = 3'd5
    } mdio_state_e;

    localparam logic [1:0] ST_C22    = 2'b01;
    localparam logic [1:0] ST_C45    = 2'b00;

    localparam logic [1:0] C22_WR    = 2'b01;
    localparam logic [1:0] C22_RD    = 2'b10;
    localparam logic [1:0] C45_ADDR  = 2'b00;
    localparam logic [1:0] C45_WR    = 2'b01;
    localparam logic [1:0] C45_RDINC = 2'b10;
    localparam logic [1:0] C45_RD    = 2'b11;

    localparam int FRAME_BITS = 32;

    function automatic logic is_read_op(input logic c45, input logic [1:0] op);
        if (c45)
            return (op == C45_RD) || (op == C45_RDINC);
        return op == C22_RD;
    endfunction

    // Clause 22 defines only read and write; the other two codes cannot be framed.
    function automatic logic is_bad_op(input logic c45, input logic [1:0] op);
        return !c45 && (op != C22_WR) && (op != C22_RD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdio_master_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdio_master_ctrl_if : request/response handshake bundle for the    |
// | MDIO master.                                     Revision: 1.0     |
// +--------------------------------------------------------------------+
interface mdio_master_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_c45;
    logic [1:0]  req_op;
    logic [4:0]  req_phy;
    logic [4:0]  req_reg;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_c45, req_op, req_phy, req_reg, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_c45, req_op, req_phy, req_reg, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/mdio_clk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdio_clk_gen : divides clk into MDC with one-cycle rise/fall       |
// | strobes; MDC parks low whenever disabled.        Revision: 1.0     |
// +--------------------------------------------------------------------+
module mdio_clk_gen #(
    parameter int CLK_DIV = 10
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en,
    output logic      mdc,
    output logic      mdc_rise,
    output logic      mdc_fall
);

    localparam logic [7:0] C_LAST = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic       r_mdc;
    logic       w_tick;

    assign w_tick   = en && (r_cnt == C_LAST);
    assign mdc_rise = w_tick && !r_mdc;
    assign mdc_fall = w_tick &&  r_mdc;
    assign mdc      = r_mdc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
            r_mdc <= 1'b0;
        end else if (!en) begin
            r_cnt <= 8'd0;
            r_mdc <= 1'b0;
        end else if (w_tick) begin
            r_cnt <= 8'd0;
            r_mdc <= ~r_mdc;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdio_master_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mdio_master_ctrl : Clause 22/45 MDIO master, one frame per request |
// | with serial shift-out, turnaround check and read capture. Rev 1.0  |
// +--------------------------------------------------------------------+
module mdio_master_ctrl
    import mdio_pkg::*;
#(
    parameter int CLK_DIV      = 10,
    parameter int PREAMBLE_LEN = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mdio_master_ctrl_if.slave ctrl,
    output logic              mdc,
    output logic              mdo,
    output logic              mdo_en,
    input  wire logic         mdi
);

    localparam logic [2:0] S_IDLE = STATE_IDLE;
    localparam logic [2:0] S_PRE  = STATE_PRE;
    localparam logic [2:0] S_HDR  = STATE_HDR;
    localparam logic [2:0] S_TA   = STATE_TA;
    localparam logic [2:0] S_DATA = STATE_DATA;
    localparam logic [2:0] S_DONE = STATE_DONE;

    localparam logic [5:0] C_PRE_INIT = (PREAMBLE_LEN == 0) ? 6'd0 : 6'(PREAMBLE_LEN - 1);

    logic [2:0]            r_state;
    logic [5:0]            r_cnt;
    logic [FRAME_BITS-1:0] r_sh;
    logic                  r_read;
    logic                  r_ta_err;
    logic [15:0]           r_rd;
    logic [15:0]           r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_mdo;
    logic                  r_mdo_en;
    logic                  w_run;
    logic                  w_rise;
    logic                  w_fall;
    logic [FRAME_BITS-1:0] w_frame;

    assign w_run   = (r_state == S_PRE) || (r_state == S_HDR) ||
                     (r_state == S_TA)  || (r_state == S_DATA);
    assign w_frame = {ctrl.req_c45 ? ST_C45 : ST_C22, ctrl.req_op, ctrl.req_phy,
                      ctrl.req_reg, 2'b10, ctrl.req_data};

    mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (w_run),
        .mdc      (mdc),
        .mdc_rise (w_rise),
        .mdc_fall (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_sh       <= '0;
            r_read     <= 1'b0;
            r_ta_err   <= 1'b0;
            r_rd       <= 16'h0000;
            r_rsp_data <= 16'h0000;
            r_rsp_err  <= 1'b0;
            r_mdo      <= 1'b1;
            r_mdo_en   <= 1'b0;
        end else begin
            // The slave's bits are sampled on the rising MDC edge; TA bit 1 must be 0.
            if (w_rise && (r_state == S_TA) && (r_cnt == 6'd0))
                r_ta_err <= mdi;
            if (w_rise && (r_state == S_DATA))
                r_rd <= {r_rd[14:0], mdi};

            case (r_state)
                S_IDLE: begin
                    if (ctrl.req_valid) begin
                        r_read   <= is_read_op(ctrl.req_c45, ctrl.req_op);
                        r_ta_err <= 1'b0;
                        if (is_bad_op(ctrl.req_c45, ctrl.req_op)) begin
                            r_state    <= S_DONE;
                            r_rsp_data <= 16'h0000;
                            r_rsp_err  <= 1'b1;
                        end else if (PREAMBLE_LEN == 0) begin
                            r_state  <= S_HDR;
                            r_cnt    <= 6'd13;
                            r_sh     <= {w_frame[FRAME_BITS-2:0], 1'b0};
                            r_mdo    <= w_frame[FRAME_BITS-1];
                            r_mdo_en <= 1'b1;
                        end else begin
                            r_state  <= S_PRE;
                            r_cnt    <= C_PRE_INIT;
                            r_sh     <= w_frame;
                            r_mdo    <= 1'b1;
                            r_mdo_en <= 1'b1;
                        end
                    end
                end
                S_PRE: begin
                    if (w_fall) begin
                        if (r_cnt == 6'd0) begin
                            r_state <= S_HDR;
                            r_cnt   <= 6'd13;
                            r_mdo   <= r_sh[FRAME_BITS-1];
                            r_sh    <= {r_sh[FRAME_BITS-2:0], 1'b0};
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                end
                S_HDR: begin
                    if (w_fall) begin
                        r_mdo <= r_sh[FRAME_BITS-1];
                        r_sh  <= {r_sh[FRAME_BITS-2:0], 1'b0};
                        if (r_cnt == 6'd0) begin
                            r_state <= S_TA;
                            r_cnt   <= 6'd1;
                            if (r_read)
                                r_mdo_en <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                end
                S_TA: begin
                    if (w_fall) begin
                        r_mdo <= r_sh[FRAME_BITS-1];
                        r_sh  <= {r_sh[FRAME_BITS-2:0], 1'b0};
                        if (r_cnt == 6'd0) begin
                            r_state <= S_DATA;
                            r_cnt   <= 6'd15;
                        end else begin
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_fall) begin
                        if (r_cnt == 6'd0) begin
                            r_state    <= S_DONE;
                            r_mdo      <= 1'b1;
                            r_mdo_en   <= 1'b0;
                            r_rsp_data <= r_read ? r_rd : 16'h0000;
                            r_rsp_err  <= r_read & r_ta_err;
                        end else begin
                            r_mdo <= r_sh[FRAME_BITS-1];
                            r_sh  <= {r_sh[FRAME_BITS-2:0], 1'b0};
                            r_cnt <= r_cnt - 6'd1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ctrl.req_ready = (r_state == S_IDLE);
    assign ctrl.busy      = (r_state != S_IDLE);
    assign ctrl.rsp_valid = (r_state == S_DONE);
    assign ctrl.rsp_data  = r_rsp_data;
    assign ctrl.rsp_err   = r_rsp_err;
    assign mdo            = r_mdo;
    assign mdo_en         = r_mdo_en;

endmodule
`default_nettype wire
